// File: rtl/sb_byte_memory_pkg.sv
// sb_mem_pkg: size encodings, FSM states and size helper for sb_byte_memory.
package sb_mem_pkg;
  localparam logic [1:0] SB_SIZE_B = 2'd0;
  localparam logic [1:0] SB_SIZE_H = 2'd1;
  localparam logic [1:0] SB_SIZE_W = 2'd2;
  localparam logic [1:0] SB_SIZE_X = 2'd3;
  typedef enum logic [1:0] {IDLE, RDWAIT, RESP} sb_state_e;
  function automatic logic [2:0] sb_nbytes(input logic [1:0] size);
    return size == SB_SIZE_B ? 3'd1 : size == SB_SIZE_H ? 3'd2 : size == SB_SIZE_W ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/sb_byte_memory_if.sv
// sb_byte_memory_if: system-bus request/response bundle for sb_byte_memory.
interface sb_byte_memory_if #(parameter int DEPTH = 128);
  logic [31:0]      sb_addr;
  logic [31:0]      sb_wdata;
  logic [1:0]       sb_size;
  logic             sb_read;
  logic             sb_write;
  logic [31:0]      sb_rdata;
  logic             sb_ready;
  logic             sb_err;
  logic [DEPTH-1:0] sb_wvalid;
  modport master (output sb_addr, sb_wdata, sb_size, sb_read, sb_write,
                  input sb_rdata, sb_ready, sb_err, sb_wvalid);
  modport slave (input sb_addr, sb_wdata, sb_size, sb_read, sb_write,
                 output sb_rdata, sb_ready, sb_err, sb_wvalid);
endinterface

// File: rtl/sb_byte_memory_check.sv
// sb_mem_check: combinational size/alignment/range checker returning error and byte-lane mask.
module sb_mem_check
  import sb_mem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  output logic        err_o,
  output logic [3:0]  lane_o
);
  logic [2:0]  nb;
  logic [32:0] end_a;
  logic        mis;
  assign nb     = sb_nbytes(size_i);
  assign end_a  = {1'b0, addr_i} + 33'(nb);
  assign mis    = size_i == SB_SIZE_H ? addr_i[0] : size_i == SB_SIZE_W ? |addr_i[1:0] : 1'b0;
  assign err_o  = size_i == SB_SIZE_X || mis || end_a > 33'(DEPTH);
  assign lane_o = size_i == SB_SIZE_B ? 4'b0001 : size_i == SB_SIZE_H ? 4'b0011 :
                  size_i == SB_SIZE_W ? 4'b1111 : 4'b0000;
endmodule

// File: rtl/sb_byte_memory.sv
// sb_byte_memory: byte-addressable system-bus memory with sized transfers and read latency.
// SB_MEM_WVALID_EN enables per-byte written tracking and the uninitialised-read error.
module sb_byte_memory
  import sb_mem_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  sb_byte_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  mem_q [DEPTH];
  sb_state_e   state_q;
  logic [2:0]  cnt_q;
  logic        ready_q, err_q, rerr_q;
  logic [31:0] rdata_q, rbuf_q, rd_word;
  logic        chk_err, req, bad, wr_en, uninit;
  logic [3:0]  lane;
  logic [AW-1:0] a;
  sb_mem_check #(.DEPTH(DEPTH)) u_check (
    .addr_i(bus.sb_addr),
    .size_i(bus.sb_size),
    .err_o (chk_err),
    .lane_o(lane)
  );
  assign a     = bus.sb_addr[AW-1:0];
  assign req   = state_q == IDLE && (bus.sb_read || bus.sb_write);
  assign bad   = chk_err || (bus.sb_read && bus.sb_write);
  assign wr_en = req && bus.sb_write && !bad;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) rd_word[8*i+:8] = lane[i] ? mem_q[a + AW'(i)] : 8'h00;
  end
  // Array is deliberately outside reset: contents survive rst.
  always_ff @(posedge clk)
    if (wr_en && !rst)
      for (int i = 0; i < 4; i++) if (lane[i]) mem_q[a + AW'(i)] <= bus.sb_wdata[8*i+:8];
`ifdef SB_MEM_WVALID_EN
  logic [DEPTH-1:0] wvalid_q;
  always_comb begin
    uninit = 1'b0;
    for (int i = 0; i < 4; i++) uninit = uninit | (lane[i] & ~wvalid_q[a + AW'(i)]);
  end
  always_ff @(posedge clk)
    if (rst) wvalid_q <= '0;
    else if (wr_en)
      for (int i = 0; i < 4; i++) if (lane[i]) wvalid_q[a + AW'(i)] <= 1'b1;
  assign bus.sb_wvalid = wvalid_q;
`else
  assign uninit        = 1'b0;
  assign bus.sb_wvalid = '0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (req) begin
            if (bad || bus.sb_write || READ_LAT == 1) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= bad || (bus.sb_read && uninit);
              if (!bad && bus.sb_read) rdata_q <= rd_word;
            end else begin
              state_q <= RDWAIT;
              cnt_q   <= 3'(READ_LAT - 1);
              rbuf_q  <= rd_word;
              rerr_q  <= uninit;
            end
          end
        RDWAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= rerr_q;
            rdata_q <= rbuf_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.sb_rdata = rdata_q;
  assign bus.sb_ready = ready_q;
  assign bus.sb_err   = err_q;
endmodule

// File: tb/tb_sb_byte_memory.sv
// tb_sb_byte_memory: randomized scoreboard bench for sb_byte_memory against a byte-array model.
module tb_sb_byte_memory;
  localparam int DEPTH    = 128;
  localparam int READ_LAT = 3;
`ifdef SB_MEM_WVALID_EN
  localparam bit WV = 1'b1;
`else
  localparam bit WV = 1'b0;
`endif
  typedef struct {
    logic [31:0]      rdata;
    logic             err;
    int               lat;
    int               acc;
    logic [DEPTH-1:0] wv;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   resp_cnt = 0;
  exp_t q[$];
  logic [7:0]       mm [DEPTH];
  logic [DEPTH-1:0] wvm = '0;
  logic [31:0]      last_rd = '0;
  sb_byte_memory_if #(.DEPTH(DEPTH)) bus ();
  sb_byte_memory #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input bit rd, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, output exp_t e);
    int nb;
    bit bad, un;
    logic [31:0] d;
    nb  = size == 2'd0 ? 1 : size == 2'd1 ? 2 : size == 2'd2 ? 4 : 0;
    bad = nb == 0 || (rd && wr) || ({32'h0, addr} + 64'(nb)) > 64'(DEPTH);
    if (!bad && (int'(addr[1:0]) % nb) != 0) bad = 1'b1;
    d  = '0;
    un = 1'b0;
    if (!bad && wr)
      for (int i = 0; i < nb; i++) begin
        mm[int'(addr) + i] = wd[8*i+:8];
        wvm[int'(addr) + i] = 1'b1;
      end
    if (!bad && rd) begin
      for (int i = 0; i < nb; i++) begin
        d  = d | (32'(mm[int'(addr) + i]) << (8 * i));
        un = un | !wvm[int'(addr) + i];
      end
      last_rd = d;
    end
    e.rdata = last_rd;
    e.err   = bad || (rd && WV && un);
    e.lat   = (rd && !bad) ? READ_LAT : 1;
    e.acc   = 0;
    e.wv    = WV ? wvm : '0;
  endtask
  // Monitor: every response pops one expectation; a response with nothing pending is spurious.
  always @(negedge clk)
    if (bus.sb_ready === 1'b1) begin
      exp_t e;
      resp_cnt++;
      if (q.size() == 0) chk("spurious_ready", 1, 0);
      else begin
        e = q.pop_front();
        chk("err", bus.sb_err, e.err);
        chk("rdata", bus.sb_rdata, e.rdata);
        chk("latency", cyc - e.acc, e.lat - 1);
        chk("wvalid", bus.sb_wvalid, e.wv);
      end
    end
  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wd);
    exp_t e;
    int snap, n;
    @(negedge clk);
    model(rd, wr, addr, size, wd, e);
    e.acc = cyc + 1;
    q.push_back(e);
    snap = resp_cnt;
    bus.sb_addr = addr;
    bus.sb_size = size;
    bus.sb_wdata = wd;
    bus.sb_read = rd;
    bus.sb_write = wr;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (resp_cnt == snap && n < 20);
    bus.sb_read = 1'b0;
    bus.sb_write = 1'b0;
    chk("resp_seen", resp_cnt != snap, 1);
    if (resp_cnt == snap) q.delete();
  endtask
  initial begin
    int snap, r;
    logic [31:0] ad;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    bus.sb_addr = '0;
    bus.sb_wdata = '0;
    bus.sb_size = 2'd0;
    bus.sb_read = 1'b0;
    bus.sb_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.sb_ready, 0);
    chk("rst_err", bus.sb_err, 0);
    chk("rst_rdata", bus.sb_rdata, 0);
    chk("rst_wvalid", bus.sb_wvalid, 0);
    rst = 1'b0;
    xact(1, 0, 32'h20, 2'd2, 0);
    chk("uninit_rdata", bus.sb_rdata, 0);
    xact(0, 1, 32'h10, 2'd2, 32'hDEADBEEF);
    xact(1, 0, 32'h10, 2'd2, 0);
    chk("word_read", bus.sb_rdata, 32'hDEADBEEF);
`ifdef SB_MEM_WVALID_EN
    chk("wvalid_19_16", bus.sb_wvalid[19:16], 4'hF);
`endif
    xact(0, 1, 32'h11, 2'd0, 32'h123456AA);
    xact(1, 0, 32'h10, 2'd1, 0);
    chk("half_read", bus.sb_rdata, 32'h0000AAEF);
    xact(0, 1, 32'h03, 2'd1, 32'h5555);
    xact(1, 0, DEPTH - 2, 2'd2, 0);
    xact(1, 0, 32'h02, 2'd3, 0);
    xact(1, 1, 32'h10, 2'd2, 32'h0);
    xact(1, 0, 32'h10, 2'd2, 0);
    xact(0, 1, DEPTH - 4, 2'd2, 32'hCAFEF00D);
    xact(1, 0, DEPTH - 4, 2'd2, 0);
    // Reset one cycle after a read accept must swallow the response.
    @(negedge clk);
    snap = resp_cnt;
    bus.sb_addr = 32'h10;
    bus.sb_size = 2'd2;
    bus.sb_read = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.sb_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wvm = '0;
    last_rd = '0;
    repeat (6) @(negedge clk);
    chk("rst_drop", resp_cnt, snap);
    chk("rst_mid_rdata", bus.sb_rdata, 0);
    chk("rst_mid_wvalid", bus.sb_wvalid, 0);
    xact(1, 0, 32'h10, 2'd2, 0);
    chk("kept_after_rst", bus.sb_rdata, 32'hDEADAAEF);
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 19);
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH + 3));
      xact(r < 9 || r == 19, r >= 9, ad, 2'($urandom_range(0, 3)), 32'($urandom));
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
